// File: rtl/outer_product_acc_pkg.sv
// Shared constants and FSM encoding for the outer-product accumulator.
// Widths are sized so three beats of 15*15 products cannot overflow.
package outer_product_acc_pkg;

    localparam int DW    = 4;
    localparam int ACC_W = 2*DW + 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/outer_product_acc_mac_cell.sv
// Single multiply-accumulate cell: acc <= clr ? 0 : en ? acc + a*b : acc.
// Latency: one clock per update; no backpressure, the caller gates en.
module mac_cell
    import outer_product_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc
);

    logic [2*DW-1:0]  prod;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-2*DW){1'b0}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/outer_product_acc.sv
// Accumulates k_len outer products w*x^T into a 3x3 array, then drains n_rows x n_cols row-major.
// Latency: first entry 1 cycle after the last beat; drain stalls on out_ready=0 with outputs held.
module outer_product_acc
    import outer_product_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             clear,
    input  logic [1:0]       k_len,
    input  logic [1:0]       n_rows,
    input  logic [1:0]       n_cols,
    input  logic [DW-1:0]    w1,
    input  logic [DW-1:0]    w2,
    input  logic [DW-1:0]    w3,
    input  logic [DW-1:0]    x1,
    input  logic [DW-1:0]    x2,
    input  logic [DW-1:0]    x3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [1:0]       out_row,
    output logic [1:0]       out_col,
    output logic             busy,
    output logic             done
);

    state_e     state_q, state_d;
    logic [1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] r_q, r_d;
    logic [1:0] c_q, c_d;
    logic [1:0] cfg_k_q, cfg_k_d;
    logic [1:0] cfg_rows_q, cfg_rows_d;
    logic [1:0] cfg_cols_q, cfg_cols_d;
    logic       acc_clr;
    logic       acc_en;

    logic [DW-1:0]    w_vec [3];
    logic [DW-1:0]    x_vec [3];
    logic [ACC_W-1:0] acc   [3][3];

    assign w_vec[0] = w1;
    assign w_vec[1] = w2;
    assign w_vec[2] = w3;
    assign x_vec[0] = x1;
    assign x_vec[1] = x2;
    assign x_vec[2] = x3;

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            mac_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (acc_clr),
                .en    (acc_en),
                .a     (w_vec[gi]),
                .b     (x_vec[gj]),
                .acc   (acc[gi][gj])
            );
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        cfg_k_d    = cfg_k_q;
        cfg_rows_d = cfg_rows_q;
        cfg_cols_d = cfg_cols_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            beat_cnt_d = 2'd0;
            r_d        = 2'd0;
            c_d        = 2'd0;
            acc_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // Keep the array pinned at zero until a real beat arrives.
                    acc_clr = 1'b1;
                    if (in_valid) begin
                        cfg_k_d    = k_len;
                        cfg_rows_d = n_rows;
                        cfg_cols_d = n_cols;
                        if (k_len == 2'd0) begin
                            state_d = DONE;
                        end else begin
                            acc_clr    = 1'b0;
                            acc_en     = 1'b1;
                            beat_cnt_d = 2'd1;
                            r_d        = 2'd0;
                            c_d        = 2'd0;
                            if (k_len != 2'd1) begin
                                state_d = ACCUM;
                            end else if (n_rows != 2'd0 && n_cols != 2'd0) begin
                                state_d = DRAIN;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_en     = 1'b1;
                        beat_cnt_d = beat_cnt_q + 2'd1;
                        if (beat_cnt_q + 2'd1 == cfg_k_q) begin
                            r_d = 2'd0;
                            c_d = 2'd0;
                            if (cfg_rows_q != 2'd0 && cfg_cols_q != 2'd0) begin
                                state_d = DRAIN;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (c_q == cfg_cols_q - 2'd1) begin
                            c_d = 2'd0;
                            if (r_q == cfg_rows_q - 2'd1) begin
                                r_d     = 2'd0;
                                state_d = DONE;
                            end else begin
                                r_d = r_q + 2'd1;
                            end
                        end else begin
                            c_d = c_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= 2'd0;
            r_q        <= 2'd0;
            c_q        <= 2'd0;
            cfg_k_q    <= 2'd0;
            cfg_rows_q <= 2'd0;
            cfg_cols_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            r_q        <= r_d;
            c_q        <= c_d;
            cfg_k_q    <= cfg_k_d;
            cfg_rows_q <= cfg_rows_d;
            cfg_cols_q <= cfg_cols_d;
        end
    end

    // Data is forced to zero outside DRAIN so idle outputs match the reset state.
    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            case ({r_q, c_q})
                4'b0000: out_data = acc[0][0];
                4'b0001: out_data = acc[0][1];
                4'b0010: out_data = acc[0][2];
                4'b0100: out_data = acc[1][0];
                4'b0101: out_data = acc[1][1];
                4'b0110: out_data = acc[1][2];
                4'b1000: out_data = acc[2][0];
                4'b1001: out_data = acc[2][1];
                4'b1010: out_data = acc[2][2];
                default: out_data = '0;
            endcase
        end
    end

    assign out_valid = (state_q == DRAIN);
    assign out_row   = r_q;
    assign out_col   = c_q;
    assign busy      = (state_q == ACCUM) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_outer_product_acc.sv
// Bench for outer_product_acc: directed and randomized jobs checked against a matrix-product model.
module tb_outer_product_acc;
    import outer_product_acc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             clear = 1'b0;
    logic             out_ready = 1'b0;
    logic [1:0]       k_len = 2'd0;
    logic [1:0]       n_rows = 2'd0;
    logic [1:0]       n_cols = 2'd0;
    logic [DW-1:0]    w1 = '0, w2 = '0, w3 = '0;
    logic [DW-1:0]    x1 = '0, x2 = '0, x3 = '0;
    logic             out_valid, busy, done;
    logic [ACC_W-1:0] out_data;
    logic [1:0]       out_row, out_col;

    int n_chk = 0;
    int n_pass = 0;
    int bw[3][3];   // [beat][row lane]
    int bx[3][3];   // [beat][col lane]

    outer_product_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .clear     (clear),
        .k_len     (k_len),
        .n_rows    (n_rows),
        .n_cols    (n_cols),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_ops(input int b);
        w1 = DW'(bw[b][0]); w2 = DW'(bw[b][1]); w3 = DW'(bw[b][2]);
        x1 = DW'(bx[b][0]); x2 = DW'(bx[b][1]); x3 = DW'(bx[b][2]);
    endtask

    task automatic scramble();
        w1 = DW'($urandom); w2 = DW'($urandom); w3 = DW'($urandom);
        x1 = DW'($urandom); x2 = DW'($urandom); x3 = DW'($urandom);
    endtask

    task automatic load_identity();
        for (int b = 0; b < 3; b++)
            for (int l = 0; l < 3; l++) begin
                bw[b][l] = (b == l) ? 1 : 0;
                bx[b][l] = 3*b + l + 1;
            end
    endtask

    task automatic load_const(input int v);
        for (int b = 0; b < 3; b++)
            for (int l = 0; l < 3; l++) begin
                bw[b][l] = v;
                bx[b][l] = v;
            end
    endtask

    task automatic load_random();
        for (int b = 0; b < 3; b++)
            for (int l = 0; l < 3; l++) begin
                bw[b][l] = int'($urandom_range(0, 15));
                bx[b][l] = int'($urandom_range(0, 15));
            end
    endtask

    // Config is scrambled after each beat: only the first beat's config may matter.
    task automatic drive_beats(input int k, input int rows, input int cols, input int gap);
        int nb;
        nb = (k == 0) ? 1 : k;
        k_len  = 2'(k);
        n_rows = 2'(rows);
        n_cols = 2'(cols);
        for (int b = 0; b < nb; b++) begin
            set_ops(b);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            k_len  = 2'($urandom);
            n_rows = 2'($urandom);
            n_cols = 2'($urandom);
            if (b == 0 && nb > 1) begin
                for (int g = 0; g < gap; g++) begin
                    scramble();
                    @(negedge clk);
                    chk("busy_gap", busy, 1);
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 three-cycle stall at entry 4.
    task automatic run_job(input int k, input int rows, input int cols, input int gap, input int rdy_mode);
        int exp_c[3][3];
        int n, e, cyc, stall;
        logic held;
        logic [ACC_W-1:0] pd;
        logic [1:0] pr, pc;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                exp_c[i][j] = 0;
                for (int b = 0; b < k; b++) exp_c[i][j] += bw[b][i] * bx[b][j];
            end
        n = (k != 0) ? rows * cols : 0;
        @(posedge clk); #1;
        drive_beats(k, rows, cols, gap);
        e = 0; cyc = 0; stall = 0; held = 1'b0;
        pd = '0; pr = '0; pc = '0;
        while (e < n && cyc < 300) begin
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (e == 4 && stall < 3) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            chk("valid_in_drain", out_valid, 1);
            if (held) begin
                chk("hold_data", out_data, pd);
                chk("hold_row", out_row, pr);
                chk("hold_col", out_col, pc);
            end
            if (out_valid && out_ready) begin
                chk("entry_data", out_data, exp_c[e / cols][e % cols]);
                chk("entry_row", out_row, e / cols);
                chk("entry_col", out_col, e % cols);
                e++;
            end
            held = out_valid && !out_ready;
            pd = out_data; pr = out_row; pc = out_col;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (e < n) chk("drain_timeout", e, n);
        @(negedge clk);
        chk("done_set", done, 1);
        chk("done_no_valid", out_valid, 0);
        chk("done_not_busy", busy, 0);
        @(posedge clk); #1;
        scramble();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_ignores_in", done, 1);
        chk("done_ignores_valid", out_valid, 0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_done", done, 0);
        chk("clear_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        load_identity();   run_job(3, 3, 3, 0, 0);
        load_const(15);    run_job(3, 3, 3, 0, 0);
        for (int l = 0; l < 3; l++) begin
            bw[0][l] = 0; bx[0][l] = 0; bw[1][l] = 0; bx[1][l] = 0;
        end
        bw[0][0] = 1; bw[0][1] = 3; bx[0][0] = 5; bx[0][1] = 6;
        bw[1][0] = 2; bw[1][1] = 4; bx[1][0] = 7; bx[1][1] = 8;
        run_job(2, 2, 2, 0, 0);
        load_identity();   run_job(3, 3, 3, 0, 2);
        load_identity();   run_job(3, 3, 3, 2, 0);

        // Abort after the first beat; the concurrent in_valid must be ignored.
        load_identity();
        @(posedge clk); #1;
        k_len = 2'd3; n_rows = 2'd3; n_cols = 2'd3;
        set_ops(0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        @(posedge clk); #1;
        set_ops(1);
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", busy, 0);
        chk("abort_done", done, 0);
        run_job(3, 3, 3, 0, 0);

        // Asynchronous reset in the middle of a drain.
        load_identity();
        @(posedge clk); #1;
        drive_beats(3, 3, 3, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_col", out_col, 0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_job(3, 3, 3, 0, 0);

        for (int t = 0; t < 30; t++) begin
            load_random();
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
